// File: rtl/sb_tx_serializer_param.sv
// sb_tx_serializer_param: packet FIFO feeding an LSB-first serializer
// that inserts a fixed idle gap after every packet.
module sb_tx_serializer_param #(
  parameter int PKT_W   = 64,
  parameter int SER_W   = 1,
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_pkt_valid,
  input  logic [PKT_W-1:0]       i_pkt_data,
  output logic                   o_pkt_ready,
  input  logic                   i_ser_en,
  input  logic                   i_flush,
  output logic [SER_W-1:0]       o_ser_data,
  output logic                   o_ser_valid,
  output logic                   o_pkt_done,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_busy
);

  localparam int BEATS = PKT_W / SER_W;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             pop;
  state_t           state;
  logic [PKT_W-1:0] shift_reg;
  logic [BW-1:0]    beat_cnt;
  logic [GW-1:0]    gap_cnt;

  // Extra pointer bit tells full from empty when addresses match.
  assign o_empty = wr_ptr == rd_ptr;
  assign o_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);
  assign o_level = wr_ptr - rd_ptr;

  assign o_pkt_ready = !o_full && !i_flush && !i_rst;
  assign wr_en       = i_pkt_valid && o_pkt_ready;
  assign pop         = (state == IDLE) && !o_empty && !i_flush;

  assign o_ser_valid = state == SHIFT;
  assign o_ser_data  = o_ser_valid ? shift_reg[SER_W-1:0] : '0;
  assign o_busy      = (state != IDLE) || !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= i_pkt_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      state      <= IDLE;
      shift_reg  <= '0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      o_pkt_done <= 1'b0;
    end else begin
      o_pkt_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            shift_reg <= mem[rd_ptr[AW-1:0]];
            beat_cnt  <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (i_ser_en) begin
            shift_reg <= shift_reg >> SER_W;
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt   <= '0;
              gap_cnt    <= '0;
              o_pkt_done <= 1'b1;
              if (GAP_CYC > 0) state <= GAP;
              else             state <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (i_ser_en) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              state   <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_tx_serializer_param.sv
// tb_sb_tx_serializer_param: scoreboard bench for the serializer,
// one task per scenario, plus a GAP_CYC=0 instance.
module tb_sb_tx_serializer_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        pkt_valid;
  logic        ser_en;
  logic [63:0] pkt_data;
  logic        pkt_ready;
  logic        ser_valid;
  logic        pkt_done;
  logic        empty;
  logic        full;
  logic        busy;
  logic [7:0]  ser_data;
  logic [2:0]  level;

  logic        z_pkt_valid;
  logic        z_ser_en;
  logic [63:0] z_pkt_data;
  logic        z_pkt_ready;
  logic        z_ser_valid;
  logic        z_pkt_done;
  logic        z_empty;
  logic        z_full;
  logic        z_busy;
  logic [7:0]  z_ser_data;
  logic [2:0]  z_level;

  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  logic [7:0]  sb[$];
  logic [7:0]  exp_b;

  sb_tx_serializer_param #(
    .PKT_W(64), .SER_W(8), .DEPTH(4), .GAP_CYC(4)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_pkt_valid(pkt_valid), .i_pkt_data(pkt_data),
    .o_pkt_ready(pkt_ready), .i_ser_en(ser_en),
    .i_flush(flush), .o_ser_data(ser_data),
    .o_ser_valid(ser_valid), .o_pkt_done(pkt_done),
    .o_empty(empty), .o_full(full),
    .o_level(level), .o_busy(busy)
  );

  sb_tx_serializer_param #(
    .PKT_W(64), .SER_W(8), .DEPTH(4), .GAP_CYC(0)
  ) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_pkt_valid(z_pkt_valid), .i_pkt_data(z_pkt_data),
    .o_pkt_ready(z_pkt_ready), .i_ser_en(z_ser_en),
    .i_flush(flush), .o_ser_data(z_ser_data),
    .o_ser_valid(z_ser_valid), .o_pkt_done(z_pkt_done),
    .o_empty(z_empty), .o_full(z_full),
    .o_level(z_level), .o_busy(z_busy)
  );

  always #5 clk = ~clk;

  // Beats are consumed at the next rising edge when valid and enabled.
  always @(negedge clk) begin
    if (pkt_done) done_cnt++;
    if (ser_valid && ser_en) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_beat: got %02h, expected no beat", ser_data);
      end else begin
        exp_b = sb.pop_front();
        if (ser_data !== exp_b) begin
          n_fail++;
          $display("FAIL sb_beat: got %02h, expected %02h",
                   ser_data, exp_b);
        end
      end
    end
  end

  function automatic void push_pkt(input logic [63:0] p);
    for (int b = 0; b < 8; b++) sb.push_back(p[8*b +: 8]);
  endfunction

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; ser_en = 1'b0;
    pkt_valid = 1'b1; pkt_data = 64'hdead_beef;
    z_pkt_valid = 1'b0; z_ser_en = 1'b0; z_pkt_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ser_valid, ser_data, pkt_done, empty, full, level, busy,
         pkt_ready} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0,
                         1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outs: got v%b d%02h dn%b e%b f%b l%0d b%b r%b",
               ser_valid, ser_data, pkt_done, empty, full, level,
               busy, pkt_ready);
    end
    n_checks++;
    if ({z_empty, z_busy, z_ser_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_z: got %b, expected 100",
               {z_empty, z_busy, z_ser_valid});
    end
    @(posedge clk); #1 rst = 1'b0; pkt_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({empty, level, pkt_ready} !== {1'b1, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_release: got e%b l%0d r%b, expected e1 l0 r1",
               empty, level, pkt_ready);
    end
  endtask

  task automatic test_single;
    logic [63:0] p = 64'h0807060504030201;
    int d0;
    @(posedge clk); #1 ser_en = 1'b1;
    d0 = done_cnt;
    pkt_valid = 1'b1; pkt_data = p; push_pkt(p);
    @(posedge clk); #1 pkt_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ser_valid, busy, level} !== {1'b0, 1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL load_cycle: got v%b b%b l%0d, expected v0 b1 l1",
               ser_valid, busy, level);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ser_valid, ser_data} !== {1'b1, 8'(i + 1)}) begin
        n_fail++;
        $display("FAIL single_beat%0d: got v%b %02h, expected v1 %02h",
                 i, ser_valid, ser_data, i + 1);
      end
    end
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      n_checks++;
      if ({ser_valid, ser_data, busy, pkt_done} !==
          {1'b0, 8'h00, 1'b1, 1'(g == 0)}) begin
        n_fail++;
        $display("FAIL single_gap%0d: got v%b d%02h b%b dn%b",
                 g, ser_valid, ser_data, busy, pkt_done);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({busy, empty} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_idle: got b%b e%b, expected b0 e1",
               busy, empty);
    end
    #1;
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL single_done: got %0d pulses, expected 1",
               done_cnt - d0);
    end
  endtask

  task automatic test_fill_stall;
    logic [63:0] p [6];
    int d0;
    int cyc;
    for (int i = 0; i < 6; i++) p[i] = {$urandom, $urandom};
    @(posedge clk); #1 ser_en = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(posedge clk);
      #1 pkt_valid = 1'b1; pkt_data = p[i];
      if (i < 5) push_pkt(p[i]);
      @(negedge clk);
      n_checks++;
      if (pkt_ready !== 1'(i < 5)) begin
        n_fail++;
        $display("FAIL fill_ready%0d: got %b, expected %b",
                 i, pkt_ready, i < 5);
      end
    end
    @(posedge clk); #1 pkt_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({level, full, pkt_ready, ser_valid} !==
        {3'd4, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL fill_full: got l%0d f%b r%b v%b, expected l4 f1 r0 v1",
               level, full, pkt_ready, ser_valid);
    end
    @(posedge clk); #1 ser_en = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (busy && cyc < 200);
    #1;
    n_checks++;
    if (cyc >= 200) begin
      n_fail++;
      $display("FAIL fill_drain: got timeout after %0d cycles, expected idle",
               cyc);
    end
    n_checks++;
    if (done_cnt - d0 != 5 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL fill_done: got %0d pulses %0d left, expected 5 and 0",
               done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_toggle;
    logic [63:0] p = 64'h1817161514131211;
    logic prev_v;
    logic prev_en;
    logic seen;
    logic [7:0] prev_d;
    int nval;
    int ngap;
    int d0;
    nval = 0; ngap = 0; prev_v = 0; prev_en = 0; seen = 0; prev_d = 0;
    @(posedge clk); #1 ser_en = 1'b0;
    d0 = done_cnt;
    pkt_valid = 1'b1; pkt_data = p; push_pkt(p);
    @(posedge clk); #1 pkt_valid = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 40; c++) begin
      ser_en = c[0];
      @(negedge clk);
      if (ser_valid) begin
        nval++;
        seen = 1'b1;
        if (prev_v && !prev_en) begin
          n_checks++;
          if (ser_data !== prev_d) begin
            n_fail++;
            $display("FAIL toggle_hold: got %02h, expected %02h",
                     ser_data, prev_d);
          end
        end
      end else if (seen && busy) begin
        ngap++;
      end
      prev_v = ser_valid; prev_en = ser_en; prev_d = ser_data;
      @(posedge clk); #1;
    end
    ser_en = 1'b1;
    n_checks++;
    if (nval != 16 || ngap != 8) begin
      n_fail++;
      $display("FAIL toggle_len: got %0d valid %0d gap, expected 16 and 8",
               nval, ngap);
    end
    n_checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_done: got %0d pulses b%b, expected 1 b0",
               done_cnt - d0, busy);
    end
  endtask

  task automatic test_flush;
    logic [63:0] p [4];
    int d0;
    for (int i = 0; i < 4; i++) p[i] = {$urandom, $urandom};
    @(posedge clk); #1 ser_en = 1'b1;
    d0 = done_cnt;
    pkt_valid = 1'b1; pkt_data = p[0]; push_pkt(p[0]);
    @(posedge clk); #1 pkt_data = p[1]; push_pkt(p[1]);
    @(posedge clk); #1 pkt_data = p[2]; push_pkt(p[2]);
    @(posedge clk); #1 pkt_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 flush = 1'b1; pkt_valid = 1'b1; pkt_data = p[3];
    @(negedge clk);
    n_checks++;
    if ({ser_valid, ser_data, level, pkt_ready} !==
        {1'b1, p[0][31:24], 3'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_pre: got v%b d%02h l%0d r%b, expected v1 %02h l2 r0",
               ser_valid, ser_data, level, pkt_ready, p[0][31:24]);
    end
    @(posedge clk); #1 flush = 1'b0; pkt_valid = 1'b0; sb.delete();
    @(negedge clk);
    n_checks++;
    if ({ser_valid, ser_data, level, empty, pkt_done, busy} !==
        {1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_post: got v%b d%02h l%0d e%b dn%b b%b",
               ser_valid, ser_data, level, empty, pkt_done, busy);
    end
    @(negedge clk);
    n_checks++;
    if ({ser_valid, level, busy} !== {1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_drop: got v%b l%0d b%b, expected v0 l0 b0",
               ser_valid, level, busy);
    end
    #1;
    n_checks++;
    if (done_cnt != d0) begin
      n_fail++;
      $display("FAIL flush_done: got %0d pulses, expected 0", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] p0;
    logic [63:0] p1;
    logic [63:0] p2;
    int d0;
    int cyc;
    int nval;
    p0 = {$urandom, $urandom};
    p1 = {$urandom, $urandom};
    p2 = {$urandom, $urandom};
    @(posedge clk); #1 ser_en = 1'b1;
    d0 = done_cnt;
    pkt_valid = 1'b1; pkt_data = p0; push_pkt(p0);
    @(posedge clk); #1 pkt_data = p1; push_pkt(p1);
    @(posedge clk); #1 pkt_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ser_valid, ser_data, level, pkt_ready} !==
        {1'b1, p0[47:40], 3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_pre: got v%b d%02h l%0d r%b, expected v1 %02h l1 r0",
               ser_valid, ser_data, level, pkt_ready, p0[47:40]);
    end
    @(posedge clk); #1 rst = 1'b0; sb.delete();
    @(negedge clk);
    n_checks++;
    if ({ser_valid, ser_data, pkt_done, empty, full, level, busy} !==
        {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_outs: got v%b d%02h dn%b e%b f%b l%0d b%b",
               ser_valid, ser_data, pkt_done, empty, full, level, busy);
    end
    #1;
    n_checks++;
    if (done_cnt != d0) begin
      n_fail++;
      $display("FAIL rstmid_done: got %0d pulses, expected 0", done_cnt - d0);
    end
    d0 = done_cnt;
    @(posedge clk); #1 pkt_valid = 1'b1; pkt_data = p2; push_pkt(p2);
    @(posedge clk); #1 pkt_valid = 1'b0;
    cyc = 0; nval = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (ser_valid) nval++;
    end while (busy && cyc < 50);
    #1;
    n_checks++;
    if (cyc >= 50 || nval != 8) begin
      n_fail++;
      $display("FAIL rstmid_again: got %0d cycles %0d valid, expected <50 and 8",
               cyc, nval);
    end
    n_checks++;
    if (done_cnt - d0 != 1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_pkt: got %0d pulses %0d left, expected 1 and 0",
               done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_gap_zero;
    logic [63:0] p0;
    logic [63:0] p1;
    logic [7:0] zq[$];
    logic [7:0] e;
    logic ev;
    p0 = {$urandom, $urandom};
    p1 = {$urandom, $urandom};
    @(posedge clk); #1 z_ser_en = 1'b1;
    z_pkt_valid = 1'b1; z_pkt_data = p0;
    for (int b = 0; b < 8; b++) zq.push_back(p0[8*b +: 8]);
    @(posedge clk); #1 z_pkt_data = p1;
    for (int b = 0; b < 8; b++) zq.push_back(p1[8*b +: 8]);
    @(posedge clk); #1 z_pkt_valid = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      ev = (i != 8) && (i != 17);
      n_checks++;
      if ({z_ser_valid, z_pkt_done} !== {ev, !ev}) begin
        n_fail++;
        $display("FAIL gap0_cyc%0d: got v%b dn%b, expected v%b dn%b",
                 i, z_ser_valid, z_pkt_done, ev, !ev);
      end
      if (z_ser_valid && zq.size() > 0) begin
        e = zq.pop_front();
        n_checks++;
        if (z_ser_data !== e) begin
          n_fail++;
          $display("FAIL gap0_beat%0d: got %02h, expected %02h",
                   i, z_ser_data, e);
        end
      end
    end
    n_checks++;
    if (zq.size() != 0 || z_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gap0_end: got %0d left b%b, expected 0 b0",
               zq.size(), z_busy);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill_stall;
    test_toggle;
    test_flush;
    test_reset_mid;
    test_gap_zero;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d beats, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sb_tx_serializer_param.md
SB_TX_SERIALIZER_PARAM -- requirements
Module: sb_tx_serializer_param

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state updates on the rising edge of i_clk.
REQ-002 Parameter PKT_W, default 64, SHALL set the packet width in bits.
REQ-003 Parameter SER_W, default 1, SHALL set the serial output width per beat; PKT_W mod SER_W SHALL equal 0; BEATS = PKT_W/SER_W.
REQ-004 Parameter DEPTH, default 4, SHALL set the FIFO depth in packets; it SHALL be a power of two and at least 2.
REQ-005 Parameter GAP_CYC, default 32, SHALL set the number of idle beats inserted after every packet; 0 is legal.
REQ-006 i_clk  input  1  serializer clock.
REQ-007 i_rst  input  1  synchronous active-high reset.
REQ-008 i_pkt_valid  input  1  packet present on i_pkt_data.
REQ-009 i_pkt_data  input  PKT_W  packet to queue.
REQ-010 o_pkt_ready  output  1  FIFO accepts a packet this cycle.
REQ-011 i_ser_en  input  1  advance enable for shift and gap counters; low stalls both.
REQ-012 i_flush  input  1  discard queued and in-flight packets.
REQ-013 o_ser_data  output  SER_W  current beat, LSB-first slice of the active packet; 0 when not shifting.
REQ-014 o_ser_valid  output  1  beat on o_ser_data is valid (drives TX clock gating).
REQ-015 o_pkt_done  output  1  one-cycle pulse per fully serialized packet.
REQ-016 o_empty, o_full  output  1 each  FIFO status.
REQ-017 o_level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-018 o_busy  output  1  high when state is not IDLE or FIFO is non-empty.

Function
REQ-019 Write handshake: o_pkt_ready = !o_full && !i_flush; a packet is written when i_pkt_valid && o_pkt_ready; no write when full, even if a pop occurs the same cycle.
REQ-020 FIFO pointers SHALL carry one extra wrap bit; full = addresses equal and wrap bits differ; empty = pointers equal; wrap-around at DEPTH-1 -> 0.
REQ-021 Simultaneous write and pop SHALL leave o_level unchanged.
REQ-022 FSM states: IDLE, SHIFT, GAP.
REQ-023 IDLE: if FIFO non-empty, pop head into the shift register, clear beat counter, go SHIFT (load edge); i_ser_en not required for the load.
REQ-024 SHIFT: o_ser_valid = 1, o_ser_data = shift_reg[SER_W-1:0]; on each edge with i_ser_en, shift right by SER_W and increment beat counter; no change when i_ser_en = 0.
REQ-025 On the edge consuming beat BEATS-1 with i_ser_en: assert o_pkt_done (registered) for exactly the next cycle; go GAP if GAP_CYC>0, else IDLE.
REQ-026 GAP: o_ser_valid = 0, o_ser_data = 0; gap counter increments on edges with i_ser_en; after GAP_CYC counted edges go IDLE.
REQ-027 Latency: packet written at edge N into empty idle block -> load at edge N+1 -> first beat valid in cycle after N+1; back-to-back packets separated by exactly GAP_CYC enabled edges plus one IDLE load cycle.
REQ-028 i_flush (any state): next edge empties FIFO (o_level = 0), clears shift register and counters, state IDLE, no o_pkt_done; flush wins over a concurrent write or load.
REQ-029 Beat and gap counters SHALL be sized $clog2(BEATS) and $clog2(GAP_CYC+1) bits and SHALL never wrap past their terminal values.

Reset
REQ-030 While i_rst = 1 at an edge: state IDLE, pointers 0, counters 0, shift register 0; o_ser_valid = 0, o_ser_data = 0, o_pkt_done = 0, o_empty = 1, o_full = 0, o_level = 0, o_busy = 0; o_pkt_ready = 0 during reset cycles.
REQ-031 Reset asserted mid-packet SHALL abort it without an o_pkt_done pulse; FIFO contents are lost.

Verification (PKT_W=64, SER_W=8, DEPTH=4, GAP_CYC=4, i_ser_en=1 unless noted)
REQ-032 Single packet 0x0807060504030201 -> o_ser_data sequence 01,02..08 over 8 valid cycles, o_pkt_done once, then 4 idle cycles, o_busy falls.
REQ-033 Write 5 packets back-to-back with consumer stalled (i_ser_en=0) -> 1 loaded, o_level reaches 4, o_full=1, o_pkt_ready=0, 6th write rejected; release -> all 5 output in order, exactly 5 done pulses.
REQ-034 Toggle i_ser_en 1/0 every cycle during SHIFT -> each beat held 2 cycles, data unchanged, gap takes 8 cycles.
REQ-035 Assert i_flush at beat 3 with 2 packets queued and i_pkt_valid=1 -> next cycle o_ser_valid=0, o_level=0, no done pulse, write dropped.
REQ-036 Assert i_rst at beat 5 -> all outputs at reset values next cycle; after release a new packet serializes normally; rerun with GAP_CYC=0 -> zero idle beats, one IDLE load cycle between packets.
